video_output_formatter: RTL and testbench
=========================================

Name: video_output_formatter

Overview:
- Final video stage, directly downstream of the vertical scanline stage.
- Takes pixel-enable-qualified RGB/HS/VS/DE from that stage and re-times it into one-clock-per-pixel strobes for the platform video output.
- Sync levels become single-cycle rising-edge pulses.
- Inserts an end-of-line control word in the first blank pixel after each active line, and measures active width and height for the platform.

Parameters:
- HS_POL, 1, input HSync polarity (1 = active high, 0 = active low).
- VS_POL, 1, input VSync polarity (1 = active high, 0 = active low).
- EOL_WORD, 24'h000001, value driven on oRGB in the first blank pixel after active video.
- CNT_W, 12, width of the active width/height counters.

Ports:
- iPCLK  in  1  pixel clock; the single clock of the block.
- iRST_N  in  1  synchronous active-low reset.
- iRGB  in  24  RGB from the scanline stage, {R,G,B}.
- iHS  in  1  HSync level.
- iVS  in  1  VSync level.
- iDE  in  1  data enable.
- iCE  in  1  pixel enable; inputs are valid only when iCE=1.
- oRGB  out  24  formatted RGB / control word.
- oHS  out  1  one-iPCLK HSync pulse.
- oVS  out  1  one-iPCLK VSync pulse.
- oDE  out  1  one-iPCLK-per-pixel data enable.
- oH_ACTIVE  out  CNT_W  pixels in the last completed active line.
- oV_ACTIVE  out  CNT_W  active lines in the last completed frame.
- oSTAT_VLD  out  1  one-cycle pulse when oV_ACTIVE/oH_ACTIVE are refreshed at frame start.

Behaviour:
- Reset: sampled only on a rising iPCLK with iRST_N=0 (synchronous, active low). Clears all outputs to 0, all counters, history registers and the primed flag. A reset mid-line or mid-frame discards partial counts.
- Normalisation: hs_n = iHS ~^ HS_POL and vs_n = iVS ~^ VS_POL, so 1 = sync active.
- Capture: on a cycle with iCE=1, register rgb_s, hs_s, vs_s, de_s and shift the previous captured values into hs_p, vs_p, de_p. On cycles with iCE=0 the capture registers hold.
- Priming: the first iCE cycle after reset loads history only and sets primed. No edge events are generated from that capture, so a sync already active at reset is not reported.
- Output cycle (out_v): the iPCLK cycle immediately after a capture cycle. Latency from an iCE=1 sample to its output is exactly 1 iPCLK.
- On out_v:
  - oDE = de_s.
  - oHS = primed & hs_s & ~hs_p.
  - oVS = primed & vs_s & ~vs_p.
  - oRGB = rgb_s if de_s. Otherwise EOL_WORD if (~de_s & de_p & primed). Otherwise 24'h0.
- When out_v=0: oDE=oHS=oVS=0 and oRGB=0. Back-to-back iCE cycles (iCE tied high) give continuous output.
- HS and VS rising on the same capture: both pulses are asserted in the same out_v cycle.
- EOL_WORD is emitted exactly once per DE falling edge, including when the falling edge coincides with an HS/VS edge.
- Width counter hcnt:
  - Set to 1 on a captured pixel with de_s=1 and de_p=0.
  - Incremented on each further captured pixel with de_s=1.
  - Saturates at 2^CNT_W-1.
  - On a DE falling edge (~de_s & de_p, primed), hcnt is loaded into oH_ACTIVE.
- Line counter vcnt:
  - Incremented (saturating) on each DE falling edge.
  - On a VS rising edge: oV_ACTIVE <= vcnt, vcnt <= 0, oSTAT_VLD pulses for 1 iPCLK in the out_v cycle.
  - If a DE falling edge and a VS rising edge occur on the same capture, that line is counted into the value latched: oV_ACTIVE = vcnt+1.
- oH_ACTIVE, oV_ACTIVE and oSTAT_VLD remain 0 until the first complete line and frame are observed.
- No back-pressure: the block is a pure pipeline and never stalls the upstream stage.

Test Plan:
- Reset and priming: hold iRST_N=0 for 4 cycles with iVS=1 (VS_POL=1), then release with iCE=1. Required: all outputs 0 during reset, and no oVS pulse on the first captured pixel.
- Pixel pipeline: iCE pulsing 1-in-4, one line with DE high for 320 captured pixels with ramp RGB 0..319. Required:
  - oDE high for exactly 320 single iPCLK cycles, each 1 cycle after its iCE.
  - oRGB matches the ramp.
  - Next out_v cycle shows oRGB=24'h000001.
  - oH_ACTIVE=320.
- Polarity: HS_POL=0, iHS falling to 0 on a CE cycle. Required: one oHS pulse of width 1 iPCLK in the following cycle, none while iHS stays 0.
- Frame measure: 224 lines of 256 active pixels, then VS rising. Required: oV_ACTIVE=224, oH_ACTIVE=256, one oSTAT_VLD pulse coincident with oVS.
- Coincident events: DE falls and HS and VS rise on the same captured pixel. Required:
  - oHS=oVS=1 and oRGB=EOL_WORD in the same cycle.
  - oV_ACTIVE includes that line.
- Saturation/reset mid-line: CNT_W=4 with a 20-pixel line. Required: oH_ACTIVE=15. Then assert reset mid-line. Required: after release, the next full 8-pixel line reports oH_ACTIVE=8.

Source files
------------

// File: rtl/video_output_formatter.sv
// Final video stage: re-times pixel-enable-qualified RGB/sync into one-clock-per-pixel
// strobes, turns sync levels into rising-edge pulses and measures active width/height.
module video_output_formatter #(
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter logic [23:0] EOL_WORD = 24'h000001,
  parameter int          CNT_W    = 12
) (
  input  logic             iPCLK,
  input  logic             iRST_N,
  input  logic [23:0]      iRGB,
  input  logic             iHS,
  input  logic             iVS,
  input  logic             iDE,
  input  logic             iCE,
  output logic [23:0]      oRGB,
  output logic             oHS,
  output logic             oVS,
  output logic             oDE,
  output logic [CNT_W-1:0] oH_ACTIVE,
  output logic [CNT_W-1:0] oV_ACTIVE,
  output logic             oSTAT_VLD
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             hsPrev, vsPrev, dePrev, primed;
  logic [CNT_W-1:0] hcnt, vcnt;

  logic             hsN, vsN;
  logic             hsRise, vsRise, deFall;
  logic [CNT_W-1:0] hcntNext, vcntLine;

  // Edges are judged between the incoming sample and the last captured one, so the
  // registered outputs land exactly one iPCLK after the iCE sample that caused them.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    hcntNext = hcnt;
    vcntLine = vcnt;
    hsN      = iHS ~^ HS_POL;
    vsN      = iVS ~^ VS_POL;
    hsRise   = primed & hsN & ~hsPrev;
    vsRise   = primed & vsN & ~vsPrev;
    deFall   = primed & ~iDE & dePrev;
    if (iDE) begin
      if (!dePrev)              hcntNext = CNT_ONE;
      else if (hcnt != CNT_MAX) hcntNext = hcnt + CNT_ONE;
    end
    if (deFall && vcnt != CNT_MAX) vcntLine = vcnt + CNT_ONE;
  end

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge iPCLK) begin
    if (!iRST_N) begin
      oRGB      <= '0;
      oHS       <= 1'b0;
      oVS       <= 1'b0;
      oDE       <= 1'b0;
      oSTAT_VLD <= 1'b0;
      oH_ACTIVE <= '0;
      oV_ACTIVE <= '0;
      hsPrev    <= 1'b0;
      vsPrev    <= 1'b0;
      dePrev    <= 1'b0;
      primed    <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
    end else begin
      oRGB      <= '0;
      oHS       <= 1'b0;
      oVS       <= 1'b0;
      oDE       <= 1'b0;
      oSTAT_VLD <= 1'b0;
      if (iCE) begin
        oDE       <= iDE;
        oHS       <= hsRise;
        oVS       <= vsRise;
        oSTAT_VLD <= vsRise;
        if (iDE)         oRGB <= iRGB;
        else if (deFall) oRGB <= EOL_WORD;
        hsPrev <= hsN;
        vsPrev <= vsN;
        dePrev <= iDE;
        primed <= 1'b1;
        hcnt   <= hcntNext;
        if (deFall) oH_ACTIVE <= hcnt;
        // A line ending on the VS capture is already folded into vcntLine.
        if (vsRise) begin
          oV_ACTIVE <= vcntLine;
          vcnt      <= '0;
        end else begin
          vcnt <= vcntLine;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_output_formatter.sv
// Randomised bench for video_output_formatter: three instances (default, inverted sync
// polarity, 4-bit counters) share one stimulus and are compared to a sample-list model.
module tb_video_output_formatter;

  localparam logic [23:0] EOL = 24'h000001;

  logic        iPCLK = 1'b0;
  logic        iRST_N;
  logic [23:0] iRGB;
  logic        iHS, iVS, iDE, iCE;

  logic [23:0] rgb0, rgb1, rgb2;
  logic        hs0, hs1, hs2, vs0, vs1, vs2, de0, de1, de2, st0, st1, st2;
  logic [11:0] ha0, ha1, va0, va1;
  logic [3:0]  ha2, va2;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 iPCLK = ~iPCLK;

  video_output_formatter dutDef (
    .iPCLK(iPCLK), .iRST_N(iRST_N), .iRGB(iRGB), .iHS(iHS), .iVS(iVS), .iDE(iDE), .iCE(iCE),
    .oRGB(rgb0), .oHS(hs0), .oVS(vs0), .oDE(de0), .oH_ACTIVE(ha0), .oV_ACTIVE(va0), .oSTAT_VLD(st0));

  video_output_formatter #(.HS_POL(1'b0), .VS_POL(1'b0)) dutPol (
    .iPCLK(iPCLK), .iRST_N(iRST_N), .iRGB(iRGB), .iHS(iHS), .iVS(iVS), .iDE(iDE), .iCE(iCE),
    .oRGB(rgb1), .oHS(hs1), .oVS(vs1), .oDE(de1), .oH_ACTIVE(ha1), .oV_ACTIVE(va1), .oSTAT_VLD(st1));

  video_output_formatter #(.CNT_W(4)) dutSat (
    .iPCLK(iPCLK), .iRST_N(iRST_N), .iRGB(iRGB), .iHS(iHS), .iVS(iVS), .iDE(iDE), .iCE(iCE),
    .oRGB(rgb2), .oHS(hs2), .oVS(vs2), .oDE(de2), .oH_ACTIVE(ha2), .oV_ACTIVE(va2), .oSTAT_VLD(st2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keeps the previous captured sample, the running length of the
  // current DE run and the number of completed lines as plain integers.
  string nm[3] = '{"def", "pol", "sat"};
  bit    primedM[3], hp[3], vp[3], dp[3];
  int    run[3], lines[3], hAct[3], vAct[3];
  logic [23:0] eRgb[3];
  bit    eHs[3], eVs[3], eDe[3], eSt[3];

  int deCount0 = 0, hsCountPol = 0, vsCount0 = 0, stCount0 = 0;

  function automatic bit activeLevel(input int k);
    return k != 1;
  endfunction

  function automatic int clampM(input int v, input int k);
    int m;
    m = (k == 2) ? 15 : 4095;
    return (v > m) ? m : v;
  endfunction

  task automatic compareOne(input int k, input logic [23:0] rgb, input logic hs, vs, de, st,
                            input logic [11:0] ha, va);
    check({nm[k], ".rgb"}, 32'(rgb), 32'(eRgb[k]));
    check({nm[k], ".hs"},  32'(hs),  32'(eHs[k]));
    check({nm[k], ".vs"},  32'(vs),  32'(eVs[k]));
    check({nm[k], ".de"},  32'(de),  32'(eDe[k]));
    check({nm[k], ".stat"}, 32'(st), 32'(eSt[k]));
    check({nm[k], ".hact"}, 32'(ha), 32'(hAct[k]));
    check({nm[k], ".vact"}, 32'(va), 32'(vAct[k]));
  endtask

  always @(posedge iPCLK) begin
    for (int k = 0; k < 3; k++) begin
      bit hn, vn, dn, hr, vr, df;
      if (!iRST_N) begin
        primedM[k] = 0; hp[k] = 0; vp[k] = 0; dp[k] = 0;
        run[k] = 0; lines[k] = 0; hAct[k] = 0; vAct[k] = 0;
        eRgb[k] = '0; eHs[k] = 0; eVs[k] = 0; eDe[k] = 0; eSt[k] = 0;
      end else if (iCE) begin
        hn = (iHS == activeLevel(k));
        vn = (iVS == activeLevel(k));
        dn = iDE;
        hr = primedM[k] && hn && !hp[k];
        vr = primedM[k] && vn && !vp[k];
        df = primedM[k] && !dn && dp[k];
        eDe[k] = dn; eHs[k] = hr; eVs[k] = vr; eSt[k] = vr;
        eRgb[k] = dn ? iRGB : (df ? EOL : 24'h0);
        if (dn) run[k] = dp[k] ? run[k] + 1 : 1;
        if (df) begin
          hAct[k] = clampM(run[k], k);
          lines[k]++;
        end
        if (vr) begin
          vAct[k] = clampM(lines[k], k);
          lines[k] = 0;
        end
        hp[k] = hn; vp[k] = vn; dp[k] = dn; primedM[k] = 1;
      end else begin
        eRgb[k] = '0; eHs[k] = 0; eVs[k] = 0; eDe[k] = 0; eSt[k] = 0;
      end
    end
    #1;
    compareOne(0, rgb0, hs0, vs0, de0, st0, ha0, va0);
    compareOne(1, rgb1, hs1, vs1, de1, st1, ha1, va1);
    compareOne(2, rgb2, hs2, vs2, de2, st2, {8'h0, ha2}, {8'h0, va2});
    if (de0) deCount0++;
    if (hs1) hsCountPol++;
    if (vs0) vsCount0++;
    if (st0) stCount0++;
  end

  task automatic cyc(input bit ce, input logic [23:0] rgb, input bit hs, vs, de);
    iCE = ce; iRGB = rgb; iHS = hs; iVS = vs; iDE = de;
    @(negedge iPCLK);
  endtask

  // gap idle cycles carrying junk (must be ignored), then one captured pixel
  task automatic pix(input int gap, input logic [23:0] rgb, input bit hs, vs, de);
    repeat (gap) cyc(1'b0, 24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    cyc(1'b1, rgb, hs, vs, de);
  endtask

  initial begin
    int len;
    iRST_N = 1'b0; iCE = 1'b1; iRGB = '0; iHS = 1'b0; iVS = 1'b1; iDE = 1'b0;

    // reset with VS already active, then release: no VS pulse from the priming capture
    repeat (4) cyc(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0);
    iRST_N = 1'b1;
    repeat (3) pix(0, 24'($urandom), 1'b0, 1'b1, 1'b0);
    check("prime.noVs", 32'(vsCount0), 32'd0);

    // 1-in-4 pixel enable, 320-pixel ramp line
    deCount0 = 0;
    for (int i = 0; i < 320; i++) pix(3, 24'(i), 1'b0, 1'b0, 1'b1);
    repeat (4) pix(3, 24'($urandom), 1'b0, 1'b0, 1'b0);
    check("line.deCount", 32'(deCount0), 32'd320);
    check("line.hact", 32'(ha0), 32'd320);
    check("line.hactSat", 32'(ha2), 32'd15);

    // active-low HS on the polarity instance: a single pulse per falling iHS
    repeat (3) pix(1, 24'($urandom), 1'b1, 1'b0, 1'b0);
    hsCountPol = 0;
    repeat (8) pix(1, 24'($urandom), 1'b0, 1'b0, 1'b0);
    check("pol.hsPulses", 32'(hsCountPol), 32'd1);

    // full frame: 224 lines of 256 pixels between two VS rising edges
    pix(0, 24'($urandom), 1'b0, 1'b1, 1'b0);
    repeat (2) pix(0, 24'($urandom), 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 224; l++) begin
      for (int p = 0; p < 256; p++) pix(0, 24'($urandom), 1'b0, 1'b0, 1'b1);
      pix(0, 24'($urandom), 1'b0, 1'b0, 1'b0);
      repeat (2) pix(0, 24'($urandom), 1'b1, 1'b0, 1'b0);
      repeat (3) pix(0, 24'($urandom), 1'b0, 1'b0, 1'b0);
    end
    stCount0 = 0;
    pix(0, 24'($urandom), 1'b0, 1'b1, 1'b0);
    check("frame.stat", 32'(stCount0), 32'd1);
    check("frame.vact", 32'(va0), 32'd224);
    check("frame.hact", 32'(ha0), 32'd256);
    check("frame.vactSat", 32'(va2), 32'd15);
    check("frame.hactSat", 32'(ha2), 32'd15);
    repeat (2) pix(0, 24'($urandom), 1'b0, 1'b0, 1'b0);

    // three lines; the last one ends on the same capture as HS and VS rising
    len = 0;
    for (int l = 0; l < 3; l++) begin
      len = int'($urandom_range(30, 5));
      for (int p = 0; p < len; p++) pix(int'($urandom_range(2, 0)), 24'($urandom), 1'b0, 1'b0, 1'b1);
      if (l < 2) repeat (3) pix(int'($urandom_range(2, 0)), 24'($urandom), 1'b0, 1'b0, 1'b0);
    end
    pix(1, 24'($urandom), 1'b1, 1'b1, 1'b0);
    check("coin.vact", 32'(va0), 32'd3);
    check("coin.hact", 32'(ha0), 32'(len));
    repeat (3) pix(0, 24'($urandom), 1'b0, 1'b0, 1'b0);

    // reset in the middle of a line, then a clean 8-pixel line
    repeat (5) pix(0, 24'($urandom), 1'b0, 1'b0, 1'b1);
    iRST_N = 1'b0;
    repeat (2) cyc(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b1);
    iRST_N = 1'b1;
    repeat (6) pix(1, 24'($urandom), 1'b0, 1'b0, 1'b1);
    repeat (3) pix(1, 24'($urandom), 1'b0, 1'b0, 1'b0);
    repeat (8) pix(int'($urandom_range(2, 0)), 24'($urandom), 1'b0, 1'b0, 1'b1);
    repeat (3) pix(1, 24'($urandom), 1'b0, 1'b0, 1'b0);
    check("rst.hactSat", 32'(ha2), 32'd8);
    check("rst.hact", 32'(ha0), 32'd8);

    // unconstrained random traffic, including random CE and sync patterns
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom), 24'($urandom), ($urandom_range(7, 0) == 0), ($urandom_range(15, 0) == 0),
          ($urandom_range(3, 0) != 0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
